// File: rtl/data_mem_pkg.sv
// ============================================================================
// Module   : data_mem_pkg
// Purpose  : Shared constants and types for the data-memory responder:
//            register-page addresses, STATUS bit positions, FSM states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_mem_pkg;

   // Memory-mapped register page at the top of the 12-bit address space
   localparam logic [11:0] ADDR_GPIO_OUT = 12'hFF0;
   localparam logic [11:0] ADDR_GPIO_IN  = 12'hFF1;
   localparam logic [11:0] ADDR_CYCLE    = 12'hFF2;
   localparam logic [11:0] ADDR_STATUS   = 12'hFF3;

   // STATUS register bit positions (sticky, write-1-to-clear)
   localparam int STATUS_CONFLICT_BIT = 0;
   localparam int STATUS_UNMAPPED_BIT = 1;

   // Access sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage : data_mem_pkg

`default_nettype wire

// File: rtl/data_mem_responder_ram.sv
// ============================================================================
// Module   : data_ram
// Purpose  : Single-port synchronous 16-bit RAM with registered read port.
//            The read port samples every cycle, so holding the address keeps
//            dout refreshed with the current contents.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_ram #(
   parameter int DEPTH = 2048,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   din,
   output logic [15:0]   dout
);

   logic [15:0] mem_q [DEPTH];

   // Write on we, read-before-write registered output every cycle
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= din;
      end
      dout <= mem_q[addr];
   end

endmodule : data_ram

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module   : data_mem_responder
// Purpose  : CPU data-memory responder: RAM plus GPIO / cycle counter /
//            sticky STATUS register page, configurable wait states and a
//            one-cycle mem_ready completion pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder
   import data_mem_pkg::*;
#(
   parameter int RAM_DEPTH   = 2048,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [11:0] ram_addr,
   input  logic [15:0] wr_data,
   input  logic [15:0] gpio_in,
   output logic [15:0] data_mem_out,
   output logic        mem_ready,
   output logic [15:0] gpio_out
);

   localparam int          RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam logic [11:0] RAM_LIMIT = 12'(RAM_DEPTH);
   localparam logic [3:0]  WAIT_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

   state_e      state_q, state_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic        w_capture;

   logic        op_wr_q;
   logic        op_conf_q;
   logic [11:0] addr_q;
   logic [15:0] wdata_q;

   logic [15:0] rdata_q, rdata_d;
   logic        ready_q, ready_d;
   logic [15:0] gpio_q, gpio_d;
   logic [1:0]  status_q, status_d;
   logic [15:0] cycle_q;

   logic              w_ram_hit;
   logic              w_unmapped;
   logic              w_ram_we;
   logic [RAM_AW-1:0] w_ram_addr;
   logic [15:0]       w_ram_dout;
   logic [15:0]       w_rd_mux;

   // Full 12-bit range check; only then is the RAM index meaningful
   assign w_ram_hit  = (addr_q < RAM_LIMIT);
   assign w_unmapped = !w_ram_hit &&
                       (addr_q != ADDR_GPIO_OUT) && (addr_q != ADDR_GPIO_IN) &&
                       (addr_q != ADDR_CYCLE)    && (addr_q != ADDR_STATUS);

   // In IDLE the RAM is pointed at the incoming address so its registered
   // output is ready by the response edge even with zero wait states.
   assign w_ram_addr = (state_q == IDLE) ? ram_addr[RAM_AW-1:0] : addr_q[RAM_AW-1:0];
   assign w_ram_we   = (state_q == RESP) && op_wr_q && w_ram_hit && !reset;

   data_ram #(
      .DEPTH (RAM_DEPTH),
      .AW    (RAM_AW)
   ) u_ram (
      .clk  (clk),
      .we   (w_ram_we),
      .addr (w_ram_addr),
      .din  (wdata_q),
      .dout (w_ram_dout)
   );

   // Next-state logic for request capture, wait countdown and response
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      w_capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_rd || mem_wr) begin
               w_capture = 1'b1;
               if (WAIT_STATES > 0) begin
                  state_d = WAIT;
                  wcnt_d  = WAIT_INIT;
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (wcnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Read-data selection for the latched address
   always_comb begin
      w_rd_mux = 16'h0000;
      if (w_ram_hit) begin
         w_rd_mux = w_ram_dout;
      end else begin
         case (addr_q)
            ADDR_GPIO_OUT: w_rd_mux = gpio_q;
            ADDR_GPIO_IN:  w_rd_mux = gpio_in;
            ADDR_CYCLE:    w_rd_mux = cycle_q;
            ADDR_STATUS:   w_rd_mux = {14'h0000, status_q};
            default:       w_rd_mux = 16'h0000;
         endcase
      end
   end

   // Response-edge effects: read data, GPIO, STATUS clear then set (set wins)
   always_comb begin
      rdata_d  = rdata_q;
      gpio_d   = gpio_q;
      status_d = status_q;
      ready_d  = 1'b0;
      if (state_q == RESP) begin
         ready_d = 1'b1;
         if (op_wr_q) begin
            if (addr_q == ADDR_GPIO_OUT) begin
               gpio_d = wdata_q;
            end
            if (addr_q == ADDR_STATUS) begin
               status_d = status_q & ~wdata_q[1:0];
            end
         end else begin
            rdata_d = w_rd_mux;
         end
         if (w_unmapped) begin
            status_d[STATUS_UNMAPPED_BIT] = 1'b1;
         end
         if (op_conf_q) begin
            status_d[STATUS_CONFLICT_BIT] = 1'b1;
         end
      end
   end

   // State register and wait counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         wcnt_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // Request latch; a simultaneous read+write is executed as a write
   always_ff @(posedge clk) begin
      if (reset) begin
         op_wr_q   <= 1'b0;
         op_conf_q <= 1'b0;
         addr_q    <= 12'h000;
         wdata_q   <= 16'h0000;
      end else if (w_capture) begin
         op_wr_q   <= mem_wr;
         op_conf_q <= mem_rd && mem_wr;
         addr_q    <= ram_addr;
         wdata_q   <= wr_data;
      end
   end

   // Output, register-page and free-running cycle counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q  <= 16'h0000;
         ready_q  <= 1'b0;
         gpio_q   <= 16'h0000;
         status_q <= 2'b00;
         cycle_q  <= 16'h0000;
      end else begin
         rdata_q  <= rdata_d;
         ready_q  <= ready_d;
         gpio_q   <= gpio_d;
         status_q <= status_d;
         cycle_q  <= cycle_q + 16'd1;
      end
   end

   assign data_mem_out = rdata_q;
   assign mem_ready    = ready_q;
   assign gpio_out     = gpio_q;

endmodule : data_mem_responder

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Self-checking bench: scoreboard with a behavioural model for the
//            WAIT_STATES=1 instance, plus directed checks on WAIT_STATES=0
//            (latency/throughput) and WAIT_STATES=3 (reset abort) instances.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

   localparam int WS = 1;
   localparam int RD = 2048;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned tb_cyc = 0;
   always @(posedge clk) tb_cyc <= tb_cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, tb_cyc);
      end
   endtask

   // ---------------- main instance (WAIT_STATES=1) ----------------
   logic        rst, rd, wr;
   logic [11:0] addr;
   logic [15:0] wd, gin, dout, gout;
   logic        rdy;

   data_mem_responder #(.RAM_DEPTH(RD), .WAIT_STATES(WS)) dut (
      .clk(clk), .reset(rst), .mem_rd(rd), .mem_wr(wr), .ram_addr(addr),
      .wr_data(wd), .gpio_in(gin), .data_mem_out(dout), .mem_ready(rdy),
      .gpio_out(gout));

   // Behavioural model state
   logic [15:0] m_ram [0:4095];
   logic [15:0] m_gpo, m_last;
   logic [1:0]  m_stat;
   int unsigned R;

   typedef struct {
      int unsigned due;
      logic [15:0] data;
      logic [15:0] gpo;
   } exp_t;
   exp_t q[$];
   exp_t e;

   // Apply one access to the model; c is the edge at which it was captured
   function automatic void model_access(input bit r, input bit w, input logic [11:0] a,
                                        input logic [15:0] d, input int unsigned c);
      exp_t x;
      if (w) begin
         if (int'(a) < RD)        m_ram[a] = d;
         else if (a == 12'hFF0)   m_gpo = d;
         else if (a == 12'hFF3)   m_stat = m_stat & ~d[1:0];
         else if (a == 12'hFF1 || a == 12'hFF2) begin end
         else                     m_stat[1] = 1'b1;
         if (r) m_stat[0] = 1'b1;
      end else begin
         if (int'(a) < RD)       m_last = m_ram[a];
         else if (a == 12'hFF0)  m_last = m_gpo;
         else if (a == 12'hFF1)  m_last = gin;
         else if (a == 12'hFF2)  m_last = 16'((c + WS - R) % 65536);
         else if (a == 12'hFF3)  m_last = {14'h0, m_stat};
         else begin
            m_last = 16'h0000;
            m_stat[1] = 1'b1;
         end
      end
      x.due  = c + 1 + WS;
      x.data = m_last;
      x.gpo  = m_gpo;
      q.push_back(x);
   endfunction

   // Present one strobe at the next edge, then wait until the DUT is idle again
   task automatic issue(input bit r, input bit w, input logic [11:0] a, input logic [15:0] d);
      rd = r; wr = w; addr = a; wd = d;
      @(posedge clk); #1;
      model_access(r, w, a, d, tb_cyc);
      rd = 1'b0; wr = 1'b0;
      repeat (WS + 1) @(posedge clk);
      #1;
   endtask

   // Monitor: pop and compare on every mem_ready, flag late or spurious pulses
   always @(negedge clk) begin
      if (rdy === 1'b1) begin
         if (q.size() == 0) begin
            check("spurious_ready", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            check("ready_cycle", tb_cyc, e.due);
            check("data_mem_out", {16'h0, dout}, {16'h0, e.data});
            check("gpio_out", {16'h0, gout}, {16'h0, e.gpo});
         end
      end else if (q.size() > 0 && tb_cyc > q[0].due) begin
         check("missing_ready", tb_cyc, q[0].due);
         void'(q.pop_front());
      end
   end

   logic [11:0] pool [12] = '{12'h000, 12'h001, 12'h010, 12'h020, 12'h030, 12'h123,
                              12'h2AA, 12'h400, 12'h555, 12'h7FE, 12'h7FF, 12'h3C3};

   task automatic main_seq();
      logic [11:0] a;
      bit r, w;
      int sel;
      int unsigned tgt;
      rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wd = '0; gin = '0;
      m_gpo = '0; m_last = '0; m_stat = '0;
      repeat (3) @(posedge clk);
      #1;
      R = tb_cyc;
      check("reset_dout", {16'h0, dout}, 32'h0);
      check("reset_ready", {31'h0, rdy}, 32'h0);
      check("reset_gpio", {16'h0, gout}, 32'h0);
      rst = 1'b0;
      // Directed scenarios
      issue(0, 1, 12'h010, 16'hBEEF);
      issue(1, 0, 12'h010, 16'h0000);
      issue(0, 1, 12'hFF0, 16'h00A5);
      gin = 16'h1234;
      issue(1, 0, 12'hFF1, 16'h0000);
      issue(0, 1, 12'hFF1, 16'hFFFF);
      issue(1, 0, 12'hFF3, 16'h0000);
      issue(1, 1, 12'h020, 16'h5555);
      issue(1, 0, 12'h020, 16'h0000);
      issue(1, 0, 12'hFF3, 16'h0000);
      issue(1, 0, 12'h900, 16'h0000);
      issue(1, 0, 12'hFF3, 16'h0000);
      issue(0, 1, 12'hFF3, 16'h0001);
      issue(1, 0, 12'hFF3, 16'h0000);
      issue(1, 1, 12'hFF3, 16'h0003);
      issue(1, 0, 12'hFF3, 16'h0000);
      issue(1, 0, 12'hFF2, 16'h0000);
      repeat (7) @(posedge clk);
      #1;
      issue(1, 0, 12'hFF2, 16'h0000);
      // Initialise the RAM pool so random reads have known contents
      for (int i = 0; i < 12; i++) issue(0, 1, pool[i], 16'($urandom));
      // Randomised traffic
      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 9);
         r = (sel < 5) || (sel == 9);
         w = (sel >= 5);
         sel = $urandom_range(0, 9);
         if (sel < 6)      a = pool[$urandom_range(0, 11)];
         else if (sel < 9) a = 12'hFF0 + 12'($urandom_range(0, 15));
         else              a = 12'h800 + 12'($urandom_range(0, 12'h7EF));
         if (w && a == 12'hFF2) a = 12'hFF0;
         gin = 16'($urandom);
         issue(r, w, a, 16'($urandom));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      // Counter wrap: capture so the response edge sees 0xFFFF+1 = 0x0000
      tgt = R - WS + 65536;
      if (tgt - 1 > tb_cyc) repeat (tgt - 1 - tb_cyc) @(posedge clk);
      #1;
      issue(1, 0, 12'hFF2, 16'h0000);
      issue(1, 0, 12'hFF2, 16'h0000);
      repeat (WS + 4) @(posedge clk);
      #1;
      check("queue_drained", q.size(), 32'd0);
   endtask

   // ---------------- zero-wait instance ----------------
   logic        rstz, rdz;
   logic [15:0] doutz, goutz;
   logic        rdyz;

   data_mem_responder #(.RAM_DEPTH(RD), .WAIT_STATES(0)) dutz (
      .clk(clk), .reset(rstz), .mem_rd(rdz), .mem_wr(1'b0), .ram_addr(12'hFF1),
      .wr_data(16'h0000), .gpio_in(16'hA5A5), .data_mem_out(doutz), .mem_ready(rdyz),
      .gpio_out(goutz));

   task automatic zero_seq();
      int unsigned rz;
      bit exp_r;
      rstz = 1'b1; rdz = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rz = tb_cyc;
      rstz = 1'b0;
      rdz = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         exp_r = (k >= 2) && (k % 2 == 0);
         check("ws0_ready", {31'h0, rdyz}, {31'h0, exp_r});
         if (exp_r) check("ws0_data", {16'h0, doutz}, 32'h0000A5A5);
      end
      rdz = 1'b0;
      check("ws0_gpio", {16'h0, goutz}, 32'h0);
      if (tb_cyc != rz + 10) check("ws0_timing", tb_cyc, rz + 10);
   endtask

   // ---------------- three-wait instance, reset abort ----------------
   logic        rst3, rd3, wr3;
   logic [11:0] addr3;
   logic [15:0] wd3, dout3, gout3;
   logic        rdy3;

   data_mem_responder #(.RAM_DEPTH(RD), .WAIT_STATES(3)) dut3 (
      .clk(clk), .reset(rst3), .mem_rd(rd3), .mem_wr(wr3), .ram_addr(addr3),
      .wr_data(wd3), .gpio_in(16'h0000), .data_mem_out(dout3), .mem_ready(rdy3),
      .gpio_out(gout3));

   task automatic acc3(input bit r, input bit w, input logic [11:0] a, input logic [15:0] d,
                       output logic [15:0] data);
      int unsigned c;
      bit seen;
      rd3 = r; wr3 = w; addr3 = a; wd3 = d;
      @(posedge clk); #1;
      c = tb_cyc;
      rd3 = 1'b0; wr3 = 1'b0;
      seen = 1'b0;
      data = 16'hxxxx;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (rdy3) begin
            check("ws3_ready_cycle", tb_cyc, c + 4);
            data = dout3;
            seen = 1'b1;
         end
      end
      if (!seen) check("ws3_ready_seen", 32'd0, 32'd1);
   endtask

   task automatic abort_seq();
      logic [15:0] v;
      rst3 = 1'b1; rd3 = 1'b0; wr3 = 1'b0; addr3 = '0; wd3 = '0;
      repeat (3) @(posedge clk);
      #1;
      rst3 = 1'b0;
      acc3(0, 1, 12'h030, 16'h1111, v);
      acc3(0, 1, 12'hFF0, 16'h00F0, v);
      acc3(1, 0, 12'h030, 16'h0000, v);
      check("ws3_read_before", {16'h0, v}, 32'h00001111);
      check("ws3_gpio_before", {16'h0, gout3}, 32'h000000F0);
      // Start a write, then reset while it is waiting
      wr3 = 1'b1; addr3 = 12'h030; wd3 = 16'h2222;
      @(posedge clk); #1;
      wr3 = 1'b0;
      @(posedge clk); #1;
      rst3 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("ws3_rst_ready", {31'h0, rdy3}, 32'h0);
         check("ws3_rst_dout", {16'h0, dout3}, 32'h0);
         check("ws3_rst_gpio", {16'h0, gout3}, 32'h0);
      end
      rst3 = 1'b0;
      @(posedge clk); #1;
      check("ws3_post_rst_ready", {31'h0, rdy3}, 32'h0);
      acc3(1, 0, 12'h030, 16'h0000, v);
      check("ws3_read_after_abort", {16'h0, v}, 32'h00001111);
   endtask

   initial begin
      fork
         main_seq();
         zero_seq();
         abort_seq();
      join
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_data_mem_responder

`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory interface. Consumes the CPU's mem_rd/mem_wr strobes and 12-bit ram_addr, and returns 16-bit read data on data_mem_out.
- Provides a single-port data RAM plus a small memory-mapped register page: GPIO, free-running cycle counter, and sticky error status.
- Inserts a configurable number of wait states and signals completion with a one-cycle mem_ready pulse.
- Sits beside the CPU core at SoC top level, in place of a bare RAM.

Parameters:
- RAM_DEPTH, 2048, number of 16-bit RAM words mapped from address 0x000 upward; must be ≤ 0xFF0.
- WAIT_STATES, 1, cycles inserted between request capture and response; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_rd  input  1  read strobe from CPU.
- mem_wr  input  1  write strobe from CPU.
- ram_addr  input  12  word address from CPU.
- wr_data  input  16  write data from CPU, sampled with mem_wr.
- gpio_in  input  16  external inputs, readable at GPIO_IN.
- data_mem_out  output  16  read data to CPU.
- mem_ready  output  1  one-cycle access-complete pulse.
- gpio_out  output  16  GPIO_OUT register value.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - data_mem_out=0x0000, mem_ready=0, gpio_out=0x0000, STATUS=0x0000, cycle counter=0.
  - RAM contents are not reset.
  - Reset asserted mid-access aborts it: a pending write is discarded and no mem_ready is issued.
- FSM states IDLE, WAIT, RESP:
  - IDLE: if mem_rd or mem_wr is high at a clock edge, latch op, ram_addr and wr_data. Go to WAIT if WAIT_STATES>0, else to RESP.
  - WAIT: wait counter loads WAIT_STATES-1 on entry and decrements each cycle; at 0, go to RESP.
  - RESP: perform the access, assert mem_ready for exactly this cycle, return to IDLE.
  - Strobes seen in WAIT or RESP are ignored; the CPU must re-present them once back in IDLE.
- Latency: strobe sampled at edge N gives mem_ready high in cycle N+1+WAIT_STATES. Back-to-back throughput is one access per WAIT_STATES+2 cycles.
- Read data:
  - data_mem_out updates at the RESP edge and is valid while mem_ready=1.
  - It holds its value until the next read completes; writes do not change data_mem_out.
- Simultaneous mem_rd and mem_wr in IDLE: the write is performed, the read is dropped, and STATUS[0] (conflict) is set.
- Address map:
  - 0x000..RAM_DEPTH-1: RAM, read/write.
  - 0xFF0 GPIO_OUT: read/write; gpio_out updates at the RESP edge of the write.
  - 0xFF1 GPIO_IN: read-only; gpio_in is sampled at the RESP edge; writes are ignored and not an error.
  - 0xFF2 CYCLE: read-only 16-bit free-running counter, +1 every cycle, wraps 0xFFFF→0x0000. A read returns the value at the RESP edge.
  - 0xFF3 STATUS: bit0 = conflict, bit1 = unmapped; bits 15:2 read 0. Write-1-to-clear per bit.
  - Any other address (RAM_DEPTH..0xFEF, 0xFF4..0xFFF) is unmapped: reads return 0x0000, writes are dropped, STATUS[1] is set.
- Same-edge STATUS set and clear: a set occurring on the same edge as a write-1-to-clear of that bit wins the set.
- Width rules: the address comparison uses all 12 bits; RAM is indexed with the low clog2(RAM_DEPTH) bits only after the range check passes.

Decomposition:
- Package data_mem_pkg holds:
  - Address constants ADDR_GPIO_OUT=12'hFF0, ADDR_GPIO_IN=12'hFF1, ADDR_CYCLE=12'hFF2, ADDR_STATUS=12'hFF3.
  - STATUS bit indices.
  - FSM state enum (IDLE, WAIT, RESP).
- One sub-module, data_ram: single-port synchronous RAM with parameters DEPTH and width 16, inputs we, addr, din, and registered output dout.

Test Plan:
- Write then read, WAIT_STATES=1: mem_wr, addr 0x010, data 0xBEEF; then mem_rd 0x010 → mem_ready pulses 2 cycles after each strobe; data_mem_out=0xBEEF.
- WAIT_STATES=0: mem_rd at edge N → mem_ready in cycle N+1. Strobe held continuously → one access every 2 cycles.
- GPIO: write 0xFF0 with 0x00A5 → gpio_out=0x00A5 at RESP. gpio_in=0x1234, read 0xFF1 → 0x1234. Write 0xFF1 → STATUS unchanged.
- Errors:
  - mem_rd=mem_wr=1 to addr 0x020 with data 0x5555 → RAM[0x020]=0x5555 and STATUS=0x0001.
  - Read 0x900 (RAM_DEPTH=2048) → 0x0000 and STATUS=0x0003.
  - Write 0xFF3 with 0x0001 → STATUS=0x0002.
- Cycle counter: two reads of 0xFF2 spaced K cycles apart differ by K mod 2^16. Forcing wrap from 0xFFFF reads 0x0000.
- Reset mid-access: with WAIT_STATES=3, issue a write to 0x030, then assert reset in WAIT → no mem_ready; a later read of 0x030 returns the old contents; all outputs are 0 during reset.
